wptr_full_gen: RTL

//  Write-domain pointer and status generator for the async FIFO.
//  - Keeps the binary write pointer and converts it to Gray with a bin2gray

---
 rtl/wptr_full_gen.sv | 97 +++++++++
 1 files changed

// File: rtl/wptr_full_gen.sv
// Async FIFO write-side pointer and status generator.
// Binary/Gray write pointer, RAM write address, full/almost-full/count/overflow.
module bin2gray #(
  parameter int W = 9
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

module wptr_full_gen #(
  parameter int ADDRSIZE     = 8,
  parameter int AFULL_THRESH = 2**ADDRSIZE - 2
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wcount,
  output logic                wovf
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AF_LVL = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] wcount_q, wcount_d;
  logic          wfull_q, wfull_d;
  logic          wafull_q, wafull_d;
  logic          wovf_q, wovf_d;

  logic          winc_ok;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] diff;
  logic [PW-1:0] full_ptr;

  always_comb begin
    winc_ok = winc & ~wfull_q;
    wbin_d  = wbin_q + {{ADDRSIZE{1'b0}}, winc_ok};
    for (int i = 0; i < PW; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
  end

  bin2gray #(
    .W (PW)
  ) u_b2g (
    .bin  (wbin_d),
    .gray (wgray_next)
  );

  // Full when the next write pointer equals the read pointer one lap ahead.
  always_comb begin
    diff     = wbin_d - rbin;
    full_ptr = {~wq2_rptr[ADDRSIZE -: 2], wq2_rptr[ADDRSIZE-2:0]};
    wptr_d   = wgray_next;
    wfull_d  = (wgray_next == full_ptr);
    wcount_d = diff;
    wafull_d = (diff >= AF_LVL);
    wovf_d   = winc & wfull_q;
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wcount_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wcount_q <= wcount_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign waddr        = wbin_q[ADDRSIZE-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = wafull_q;
  assign wcount       = wcount_q;
  assign wovf         = wovf_q;

endmodule
